// File: rtl/time_pkg.sv
//==============================================================================
// Module      : time_pkg
// Description : Shared types and constants for the time-setting controller:
//               FSM state encoding, blink field selects and BCD field limits.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package time_pkg;

    // Controller states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SET_HH = 2'd1,
        ST_SET_MM = 2'd2,
        ST_SET_SS = 2'd3
    } state_t;

    // Field select presented to the display for blanking
    localparam logic [1:0] BLINK_HH   = 2'b00;
    localparam logic [1:0] BLINK_MM   = 2'b01;
    localparam logic [1:0] BLINK_SS   = 2'b10;
    localparam logic [1:0] BLINK_NONE = 2'b11;

    // Highest legal packed-BCD value of each field
    localparam logic [7:0] HH_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

endpackage

`default_nettype wire

// File: rtl/bcd_field_inc.sv
//==============================================================================
// Module      : bcd_field_inc
// Description : Combinational increment of one packed-BCD {tens,units} field
//               with a wrap to 00 once the field has reached its maximum.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_field_inc (
    input  logic [7:0] val,
    input  logic [7:0] max_val,
    output logic [7:0] nxt,
    output logic       wrap
);

    // BCD ordering matches binary ordering, so >= also folds any stray
    // out-of-range value back to 00 instead of walking through illegal codes
    assign wrap = (val >= max_val);

    // Next value: wrap to 00, carry units 9 into tens, or bump units
    always_comb begin
        nxt = 8'h00;
        if (wrap) begin
            nxt = 8'h00;
        end else if (val[3:0] >= 4'd9) begin
            nxt = {val[7:4] + 4'd1, 4'd0};
        end else begin
            nxt = {val[7:4], val[3:0] + 4'd1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/time_set_ctrl.sv
//==============================================================================
// Module      : time_set_ctrl
// Description : Time-of-day keeper with a button-driven set mode. Holds the
//               hh:mm:ss BCD registers, the RUN/SET state machine and the
//               half-second blink phase used to blank the selected field.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module time_set_ctrl
    import time_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_inc,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       blink_en,
    output logic [1:0] blink_sel,
    output logic       setting
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_hh;
    logic [7:0] r_mm;
    logic [7:0] r_ss;
    logic [7:0] w_hh_nxt;
    logic [7:0] w_mm_nxt;
    logic [7:0] w_ss_nxt;
    logic       r_blink_phase;
    logic       w_blink_phase_nxt;

    logic [7:0] w_hh_inc;
    logic [7:0] w_mm_inc;
    logic [7:0] w_ss_inc;
    logic       w_hh_wrap;
    logic       w_mm_wrap;
    logic       w_ss_wrap;

    bcd_field_inc u_inc_ss (
        .val     (r_ss),
        .max_val (MS_MAX),
        .nxt     (w_ss_inc),
        .wrap    (w_ss_wrap)
    );

    bcd_field_inc u_inc_mm (
        .val     (r_mm),
        .max_val (MS_MAX),
        .nxt     (w_mm_inc),
        .wrap    (w_mm_wrap)
    );

    bcd_field_inc u_inc_hh (
        .val     (r_hh),
        .max_val (HH_MAX),
        .nxt     (w_hh_inc),
        .wrap    (w_hh_wrap)
    );

    // Next state: btn_mode dominates btn_sel; btn_sel is ignored in RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (btn_mode) w_state_nxt = ST_SET_HH;
            end
            ST_SET_HH: begin
                if (btn_mode)     w_state_nxt = ST_RUN;
                else if (btn_sel) w_state_nxt = ST_SET_MM;
            end
            ST_SET_MM: begin
                if (btn_mode)     w_state_nxt = ST_RUN;
                else if (btn_sel) w_state_nxt = ST_SET_SS;
            end
            ST_SET_SS: begin
                if (btn_mode)     w_state_nxt = ST_RUN;
                else if (btn_sel) w_state_nxt = ST_SET_HH;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Next time: ripple-carry tick in RUN, single-field increment in SET
    always_comb begin
        w_hh_nxt = r_hh;
        w_mm_nxt = r_mm;
        w_ss_nxt = r_ss;
        if (r_state == ST_RUN) begin
            if (tick_1hz) begin
                w_ss_nxt = w_ss_inc;
                if (w_ss_wrap) begin
                    w_mm_nxt = w_mm_inc;
                    if (w_mm_wrap) w_hh_nxt = w_hh_inc;
                end
            end
        end else if (btn_inc && !btn_mode && !btn_sel) begin
            case (r_state)
                ST_SET_HH: w_hh_nxt = w_hh_inc;
                ST_SET_MM: w_mm_nxt = w_mm_inc;
                ST_SET_SS: w_ss_nxt = w_ss_inc;
                default:   w_hh_nxt = r_hh;
            endcase
        end
    end

    // Blink phase restarts visible on any state change, else toggles at 2 Hz
    always_comb begin
        w_blink_phase_nxt = r_blink_phase;
        if (w_state_nxt != r_state) begin
            w_blink_phase_nxt = 1'b0;
        end else if (tick_2hz) begin
            w_blink_phase_nxt = ~r_blink_phase;
        end
    end

    // State, time and blink registers; reset discards any edit in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_hh          <= 8'h00;
            r_mm          <= 8'h00;
            r_ss          <= 8'h00;
            r_blink_phase <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hh          <= w_hh_nxt;
            r_mm          <= w_mm_nxt;
            r_ss          <= w_ss_nxt;
            r_blink_phase <= w_blink_phase_nxt;
        end
    end

    // Status outputs decode the registered state only
    always_comb begin
        setting   = (r_state != ST_RUN);
        blink_sel = BLINK_NONE;
        case (r_state)
            ST_SET_HH: blink_sel = BLINK_HH;
            ST_SET_MM: blink_sel = BLINK_MM;
            ST_SET_SS: blink_sel = BLINK_SS;
            default:   blink_sel = BLINK_NONE;
        endcase
        blink_en = setting & r_blink_phase;
    end

    assign hh = r_hh;
    assign mm = r_mm;
    assign ss = r_ss;

endmodule

`default_nettype wire

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (50 MHz); all logic on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: tick_1hz  in  1  single-cycle pulse, once per second.
REQ-004 SHALL have port: tick_2hz  in  1  single-cycle pulse, twice per second.
REQ-005 SHALL have port: btn_mode  in  1  debounced single-cycle pulse; enter/leave set mode.
REQ-006 SHALL have port: btn_sel  in  1  debounced single-cycle pulse; next field.
REQ-007 SHALL have port: btn_inc  in  1  debounced single-cycle pulse; increment selected field.
REQ-008 SHALL have ports: hh, mm, ss  out  8 each  packed BCD {tens, units}, registered.
REQ-009 SHALL have port: blink_en  out  1  1 = selected field blanked this half-second.
REQ-010 SHALL have port: blink_sel  out  2  00 HH, 01 MM, 10 SS, 11 none.
REQ-011 SHALL have port: setting  out  1  1 while in any SET state.

Function
REQ-012 SHALL implement FSM states RUN, SET_HH, SET_MM, SET_SS.
REQ-013 SHALL transition RUN -> SET_HH on btn_mode; SET_* -> RUN on btn_mode.
REQ-014 SHALL cycle SET_HH -> SET_MM -> SET_SS -> SET_HH on btn_sel; btn_sel in RUN ignored.
REQ-015 In RUN, SHALL advance ss by 1 on tick_1hz, carrying ss 59->00 into mm, mm 59->00 into hh, hh 23->00; 23:59:59 -> 00:00:00 in one cycle.
REQ-016 In SET_*, SHALL ignore tick_1hz (time frozen, no catch-up).
REQ-017 In SET_*, btn_inc SHALL increment only the selected field, wrapping hh 23->00 and mm/ss 59->00 with no carry into other fields.
REQ-018 SHALL update outputs one cycle after the triggering pulse (registered, latency 1).
REQ-019 BCD arithmetic: units 9->0 with tens+1; fields never hold non-BCD or out-of-range values.
REQ-020 Simultaneous btn_mode with btn_sel/btn_inc SHALL act on btn_mode only; btn_sel with btn_inc same cycle SHALL act on btn_sel only.
REQ-021 Simultaneous tick_1hz and btn_mode in RUN SHALL apply the tick and enter SET_HH in the same cycle.
REQ-022 blink_phase register SHALL toggle on tick_2hz and clear to 0 on every state change, so a newly selected field is visible immediately.
REQ-023 blink_en SHALL equal setting AND blink_phase; blink_en = 0 in RUN.
REQ-024 blink_sel SHALL be 00/01/10 in SET_HH/SET_MM/SET_SS, 11 in RUN.

Reset
REQ-025 On rst_n low, SHALL asynchronously force state RUN, hh = mm = ss = 8'h00, blink_phase = 0, blink_en = 0, blink_sel = 2'b11, setting = 0.
REQ-026 Reset asserted mid-edit SHALL discard the edit; no partial field value survives.
REQ-027 After release, first tick_1hz SHALL produce 00:00:01.

Structure
REQ-028 Package time_pkg SHALL hold the state enum, blink_sel encodings (BLINK_HH/MM/SS/NONE) and limits HH_MAX = 8'h23, MS_MAX = 8'h59.
REQ-029 SHALL instantiate one sub-module bcd_field_inc (combinational: 8-bit BCD in, max in; next value and wrap flag out), used three times for ss, mm, hh.
REQ-030 The time registers, FSM and blink logic SHALL live in time_set_ctrl; outputs connect directly to display_mux hh/mm/ss/blink_en/blink_sel.

Verification
REQ-031 Preload 23:59:58 via SET mode, return to RUN, two tick_1hz -> 23:59:59 then 00:00:00.
REQ-032 RUN, btn_mode -> setting = 1, blink_sel = 00, blink_en = 0; after one tick_2hz -> blink_en = 1; btn_sel -> blink_sel = 01, blink_en = 0.
REQ-033 SET_MM at mm = 59, btn_inc -> mm = 00, hh unchanged; SET_HH at hh = 23, btn_inc -> hh = 00.
REQ-034 SET_SS, 5 tick_1hz pulses -> ss unchanged; btn_mode -> RUN, blink_sel = 11, next tick advances ss by 1.
REQ-035 Same-cycle btn_mode + btn_inc in SET_HH at hh = 05 -> state RUN, hh = 05.
REQ-036 Assert rst_n low during SET_MM with mm = 37 -> all outputs at reset values immediately; after release state RUN, 00:00:00.
